// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_pkg
// Brief    : Shared encodings for the CPU instruction/data memory arbiter.
// Revision : 1.0
// ============================================================================
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  // Wide enough for the largest legal starvation limit (15).
  localparam int c_STREAK_W = 4;

  function automatic logic [c_STREAK_W-1:0] streak_inc(
    input logic [c_STREAK_W-1:0] cur,
    input logic [c_STREAK_W-1:0] limit
  );
    return (cur == limit) ? cur : cur + {{(c_STREAK_W-1){1'b0}}, 1'b1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_arbiter
// Brief    : Data-priority arbiter sharing one split-handshake memory port
//            between instruction fetch and data access, with fetch
//            starvation guard and fetch cancel on flush.
// Revision : 1.0
// ============================================================================
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inst_req,
  input  logic [AW-1:0] i_inst_addr,
  input  logic          i_inst_cancel,
  output logic          o_inst_ack,
  output logic [DW-1:0] o_inst_rdata,
  input  logic          i_data_req,
  input  logic          i_data_wr,
  input  logic [3:0]    i_data_wen,
  input  logic [AW-1:0] i_data_addr,
  input  logic [DW-1:0] i_data_wdata,
  output logic          o_data_ack,
  output logic [DW-1:0] o_data_rdata,
  output logic          o_mem_req,
  output logic          o_mem_wr,
  output logic [3:0]    o_mem_wen,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_addr_ok,
  input  logic          i_mem_data_ok,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam logic [c_STREAK_W-1:0] c_LIMIT = c_STREAK_W'(STARVE_LIMIT);

  state_t                r_state;
  owner_t                r_owner;
  logic                  r_cancel;
  logic [c_STREAK_W-1:0] r_streak;
  logic                  r_mem_req;
  logic                  r_wr;
  logic [3:0]            r_wen;
  logic [AW-1:0]         r_addr;
  logic [DW-1:0]         r_wdata;
  logic                  r_inst_ack;
  logic                  r_data_ack;
  logic [DW-1:0]         r_inst_rdata;
  logic [DW-1:0]         r_data_rdata;

  logic w_grant_inst;
  logic w_grant_data;
  logic w_inst_cancel;
  logic w_cancelled;

  // Data normally wins; a saturated streak hands the port to a waiting fetch.
  assign w_grant_inst  = i_inst_req & ~i_inst_cancel & (~i_data_req | (r_streak == c_LIMIT));
  assign w_grant_data  = i_data_req & ~w_grant_inst;
  assign w_inst_cancel = i_inst_cancel & (r_owner == OWN_INST);
  assign w_cancelled   = r_cancel | w_inst_cancel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_INST;
      r_cancel     <= 1'b0;
      r_streak     <= '0;
      r_mem_req    <= 1'b0;
      r_wr         <= 1'b0;
      r_wen        <= 4'h0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_inst_ack   <= 1'b0;
      r_data_ack   <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      r_inst_ack <= 1'b0;
      r_data_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_inst || !i_inst_req) begin
            r_streak <= '0;
          end else if (w_grant_data) begin
            r_streak <= streak_inc(r_streak, c_LIMIT);
          end
          r_cancel <= 1'b0;
          if (w_grant_inst) begin
            r_owner   <= OWN_INST;
            r_addr    <= i_inst_addr;
            r_wr      <= 1'b0;
            r_wen     <= 4'h0;
            r_wdata   <= '0;
            r_mem_req <= 1'b1;
            r_state   <= ST_REQ;
          end else if (w_grant_data) begin
            r_owner   <= OWN_DATA;
            r_addr    <= i_data_addr;
            r_wr      <= i_data_wr;
            r_wen     <= i_data_wen;
            r_wdata   <= i_data_wdata;
            r_mem_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          // Acceptance beats a same-cycle cancel: the memory already owns it.
          if (i_mem_addr_ok) begin
            r_mem_req <= 1'b0;
            r_cancel  <= w_inst_cancel;
            r_state   <= ST_WAIT;
          end else if (w_inst_cancel) begin
            r_mem_req <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          r_cancel <= w_cancelled;
          if (i_mem_data_ok) begin
            r_state <= ST_DONE;
            if (r_owner == OWN_DATA) begin
              r_data_rdata <= i_mem_rdata;
              r_data_ack   <= 1'b1;
            end else if (!w_cancelled) begin
              r_inst_rdata <= i_mem_rdata;
              r_inst_ack   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_cancel <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_wr     = r_wr;
  assign o_mem_wen    = r_wen;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_inst_ack   = r_inst_ack;
  assign o_data_ack   = r_data_ack;
  assign o_inst_rdata = r_inst_rdata;
  assign o_data_rdata = r_data_rdata;

endmodule
`default_nettype wire

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-port, split-handshake memory port between the CPU's instruction-fetch requester and data-access requester.
- Sits between the core's fetch/mem stages and the memory bridge.
- Fixed data-over-instruction priority, with a starvation guard for fetch.
- At most one outstanding transaction; supports cancelling an in-flight fetch on pipeline flush.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while inst_req is pending before inst is forced to win (legal range 1..15).
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- inst_req  in  1  fetch request; held until inst_ack or inst_cancel
- inst_addr  in  AW  fetch address; stable while inst_req
- inst_cancel  in  1  flush: abandon the current/pending fetch
- inst_ack  out  1  one-cycle pulse; inst_rdata valid this cycle
- inst_rdata  out  DW  fetched word
- data_req  in  1  data request; held until data_ack
- data_wr  in  1  1=write, 0=read
- data_wen  in  4  byte write enables
- data_addr  in  AW  data address
- data_wdata  in  DW  store data
- data_ack  out  1  one-cycle pulse; data_rdata valid this cycle (reads)
- data_rdata  out  DW  load data
- mem_req  out  1  memory request valid
- mem_wr  out  1  memory write
- mem_wen  out  4  memory byte enables (0 for reads)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_addr_ok  in  1  request accepted this cycle (mem_req & mem_addr_ok)
- mem_data_ok  in  1  response/write-complete this cycle
- mem_rdata  in  DW  response data, valid with mem_data_ok

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; cancel flag=0; streak counter=0.
  - All outputs 0: mem_req, mem_wr, mem_wen, mem_addr, mem_wdata, inst_ack, data_ack, inst_rdata, data_rdata.
  - Reset mid-transaction abandons it; mem_data_ok arriving in IDLE is ignored.
- FSM states IDLE, REQ, WAIT, DONE.
- IDLE arbitration:
  - grant_inst = inst_req & ~inst_cancel & (~data_req | streak==STARVE_LIMIT).
  - grant_data = data_req & ~grant_inst.
  - On grant: latch owner, addr, wr, wen, wdata into registers and go to REQ. Inst grant always latches wr=0, wen=0.
- REQ:
  - mem_req=1; memory outputs come from the latched registers only.
  - mem_addr_ok=1 goes to WAIT.
  - Owner=inst and inst_cancel=1 with mem_addr_ok=0: return to IDLE (request withdrawn; mem_req low next cycle).
  - Cancel with mem_addr_ok=1 in the same cycle: the transaction counts as accepted; go to WAIT with cancel flag=1.
- WAIT:
  - mem_req=0.
  - inst_cancel while owner=inst sets the cancel flag.
  - mem_data_ok=1: capture mem_rdata into owner's rdata register (unless cancelled) and go to DONE.
- DONE (one cycle):
  - Owner's ack=1, except no inst_ack if the cancel flag is set. Flag cleared.
  - No arbitration in DONE, so a requester's stale req is never double-issued. Next state IDLE.
- Latency: grant at cycle t, mem_req at t+1, with zero-wait memory (addr_ok at t+1, data_ok at t+2) ack at t+3. Throughput is one transaction per 4 cycles minimum.
- Streak counter:
  - On grant_data while inst_req=1: counter +1, saturating at STARVE_LIMIT.
  - On grant_inst or inst_req=0 in IDLE: counter cleared.
- Data transactions are never cancelled. inst_cancel has no effect when owner=data.
- mem_data_ok in IDLE, REQ or DONE is a protocol error and is ignored.
- rdata outputs hold their last captured value between acks.

Decomposition:
- Shared package cpu_mem_pkg: state encoding (IDLE/REQ/WAIT/DONE, 2-bit), owner encoding (OWN_INST=0, OWN_DATA=1), counter width derived from STARVE_LIMIT (4 bits).
- Single module, no sub-module needed. Arbitration is combinational in IDLE; the FSM and latch registers live in one sequential process.

Test Plan:
- Inst-only read: inst_req, inst_addr=0xBFC00000, addr_ok immediate, data_ok next cycle with rdata=0x3C1D0000 -> mem_req high 1 cycle, mem_wen=0, inst_ack pulse 3 cycles after grant, inst_rdata=0x3C1D0000.
- Simultaneous requests: inst_req and data_req(write, addr=0x80001000, wen=0xF, wdata=0x12345678) in the same cycle -> data served first (mem_wr=1, mem_wen=0xF), then inst. data_ack precedes inst_ack.
- Starvation: data_req held continuously (ack'd and re-raised), inst_req held, STARVE_LIMIT=4 -> exactly 4 data grants, then the inst grant, then the counter reads 0.
- Cancel in WAIT: inst granted, inst_cancel during WAIT, data_ok with rdata=0xDEADBEEF -> no inst_ack, inst_rdata unchanged, state IDLE 1 cycle after DONE.
- Cancel in REQ with addr_ok stalled low -> mem_req drops the next cycle, no WAIT, a subsequent data_req is granted in the following IDLE.
- Reset mid-WAIT: rst=1 one cycle -> all outputs 0 next cycle. A later stray mem_data_ok produces no ack.
